// File: rtl/hmc6502_pkg.sv
// Shared types and constants for the 6502 interrupt/reset entry sequencer.
package hmc6502_pkg;

   typedef enum logic [1:0] {K_RESET, K_NMI, K_BRK, K_IRQ} int_kind_t;

   typedef enum logic [2:0] {
      S_RST_HOLD,
      S_IDLE,
      S_PUSH_PCH,
      S_PUSH_PCL,
      S_PUSH_P,
      S_VEC_LO,
      S_VEC_HI
   } isq_state_t;

   localparam logic [15:0] C_VEC_NMI    = 16'hFFFA;
   localparam logic [15:0] C_VEC_RESET  = 16'hFFFC;
   localparam logic [15:0] C_VEC_IRQ    = 16'hFFFE;
   localparam logic [7:0]  C_STACK_PAGE = 8'h01;

   localparam int P_B_BIT = 4;
   localparam int P_I_BIT = 2;
   localparam int P_U_BIT = 5;

endpackage

// File: rtl/int_priority.sv
// Combinational interrupt arbitration: NMI > BRK > IRQ.
module int_priority
   import hmc6502_pkg::*;
(
   input  logic      nmi_pend,
   input  logic      brk_req,
   input  logic      irq_req,
   input  logic      i_flag,
   input  logic      instr_bnd,
   output logic      valid,
   output int_kind_t kind
);

   always_comb begin
      valid = 1'b1;
      kind  = K_NMI;
      if (nmi_pend && instr_bnd) begin
         kind = K_NMI;
      end else if (brk_req) begin
         kind = K_BRK;
      end else if (irq_req && !i_flag && instr_bnd) begin
         kind = K_IRQ;
      end else begin
         valid = 1'b0;
         kind  = K_IRQ;
      end
   end

endmodule

// File: rtl/interrupt_sequencer.sv
// Owns the datapath during RESET/NMI/BRK/IRQ entry: three stack pushes then a vector fetch.
module interrupt_sequencer
   import hmc6502_pkg::*;
#(
   parameter logic [15:0] VEC_NMI    = C_VEC_NMI,
   parameter logic [15:0] VEC_RESET  = C_VEC_RESET,
   parameter logic [15:0] VEC_IRQ    = C_VEC_IRQ,
   parameter logic [7:0]  STACK_PAGE = C_STACK_PAGE
) (
   input  logic        ph1,
   input  logic        reset,
   input  logic        nmi_req,
   input  logic        irq_req,
   input  logic        brk_req,
   input  logic        instr_bnd,
   input  logic [7:0]  p,
   input  logic [15:0] pc,
   input  logic [7:0]  sp,
   output logic        busy,
   output logic [15:0] addr_out,
   output logic [7:0]  data_out,
   output logic        read_en,
   output logic        sp_dec,
   output logic        pcl_load,
   output logic        pch_load,
   output logic        set_i,
   output logic        done
);

   isq_state_t  state, state_nxt;
   int_kind_t   kind, kind_nxt, eff_kind, acc_kind;
   logic        acc_vld;
   logic        nmi_q, nmi_pend, nmi_clr;
   logic [15:0] vec;
   logic [7:0]  p_push;

   int_priority u_prio (
      .nmi_pend  (nmi_pend),
      .brk_req   (brk_req),
      .irq_req   (irq_req),
      .i_flag    (p[P_I_BIT]),
      .instr_bnd (instr_bnd),
      .valid     (acc_vld),
      .kind      (acc_kind)
   );

   always_ff @(posedge ph1) begin
      nmi_q <= nmi_req;
      if (reset) begin
         state    <= S_RST_HOLD;
         kind     <= K_RESET;
         nmi_pend <= 1'b0;
      end else begin
         state    <= state_nxt;
         kind     <= kind_nxt;
         // a fresh edge in the clearing cycle is a new NMI and must survive
         nmi_pend <= (nmi_req & ~nmi_q) | (nmi_pend & ~nmi_clr);
      end
   end

   always_comb begin
      state_nxt = state;
      kind_nxt  = kind;
      nmi_clr   = 1'b0;
      busy      = 1'b1;
      addr_out  = '0;
      data_out  = '0;
      read_en   = 1'b1;
      sp_dec    = 1'b0;
      pcl_load  = 1'b0;
      pch_load  = 1'b0;
      set_i     = 1'b0;
      done      = 1'b0;

      // pending NMI steals the vector of a BRK/IRQ entry; latched into kind for VEC_HI
      eff_kind = kind;
      if (state == S_VEC_LO && nmi_pend && (kind == K_BRK || kind == K_IRQ))
         eff_kind = K_NMI;
      case (eff_kind)
         K_RESET: vec = VEC_RESET;
         K_NMI:   vec = VEC_NMI;
         default: vec = VEC_IRQ;
      endcase

      p_push = p;
      p_push[P_U_BIT] = 1'b1;
      if (kind == K_BRK) p_push[P_B_BIT] = 1'b1;

      case (state)
         S_RST_HOLD: state_nxt = S_PUSH_PCH;
         S_IDLE: begin
            busy = 1'b0;
            if (acc_vld) begin
               kind_nxt  = acc_kind;
               state_nxt = S_PUSH_PCH;
            end
         end
         S_PUSH_PCH: begin
            addr_out  = {STACK_PAGE, sp};
            data_out  = pc[15:8];
            read_en   = (kind == K_RESET);
            sp_dec    = 1'b1;
            state_nxt = S_PUSH_PCL;
         end
         S_PUSH_PCL: begin
            addr_out  = {STACK_PAGE, sp};
            data_out  = pc[7:0];
            read_en   = (kind == K_RESET);
            sp_dec    = 1'b1;
            state_nxt = S_PUSH_P;
         end
         S_PUSH_P: begin
            addr_out  = {STACK_PAGE, sp};
            data_out  = p_push;
            read_en   = (kind == K_RESET);
            sp_dec    = 1'b1;
            state_nxt = S_VEC_LO;
         end
         S_VEC_LO: begin
            addr_out  = vec;
            pcl_load  = 1'b1;
            set_i     = 1'b1;
            kind_nxt  = eff_kind;
            nmi_clr   = (eff_kind == K_NMI);
            state_nxt = S_VEC_HI;
         end
         S_VEC_HI: begin
            addr_out  = vec + 16'd1;
            pch_load  = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_RST_HOLD;
      endcase

      // the reset cycle itself must never leak a push or load strobe
      if (reset) begin
         busy     = 1'b1;
         addr_out = '0;
         data_out = '0;
         read_en  = 1'b1;
         sp_dec   = 1'b0;
         pcl_load = 1'b0;
         pch_load = 1'b0;
         set_i    = 1'b0;
         done     = 1'b0;
      end
   end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed + random bench for interrupt_sequencer with a queue-based sequence model.
module tb_interrupt_sequencer;

   localparam int KR = 0, KN = 1, KB = 2, KI = 3;

   typedef struct {
      int step;
      int kind;
   } rec_t;

   logic        ph1 = 1'b0;
   logic        reset, nmi_req, irq_req, brk_req, instr_bnd;
   logic [7:0]  p, sp;
   logic [15:0] pc;
   logic        busy, read_en, sp_dec, pcl_load, pch_load, set_i, done;
   logic [15:0] addr_out;
   logic [7:0]  data_out;

   int   n_cmp = 0;
   int   n_err = 0;
   rec_t q[$];
   logic m_hold = 1'b0;
   logic m_pend = 1'b0;
   logic m_nprev = 1'b0;

   logic        o_busy, o_rd, o_spd, o_pcl, o_pch, o_seti, o_done;
   logic [15:0] o_addr;
   logic [7:0]  o_data;

   interrupt_sequencer dut (
      .ph1(ph1), .reset(reset), .nmi_req(nmi_req), .irq_req(irq_req),
      .brk_req(brk_req), .instr_bnd(instr_bnd), .p(p), .pc(pc), .sp(sp),
      .busy(busy), .addr_out(addr_out), .data_out(data_out), .read_en(read_en),
      .sp_dec(sp_dec), .pcl_load(pcl_load), .pch_load(pch_load), .set_i(set_i),
      .done(done)
   );

   always #5 ph1 = ~ph1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] vec_of(input int k);
      if (k == KR) return 16'hFFFC;
      if (k == KN) return 16'hFFFA;
      return 16'hFFFE;
   endfunction

   task automatic queue_seq(input int k);
      for (int s = 0; s < 5; s++) q.push_back('{step: s, kind: k});
   endtask

   // One clock: predict this cycle's outputs from the entry rules, compare, advance.
   task automatic tick();
      logic        e_busy, e_rd, e_spd, e_pcl, e_pch, e_seti, e_done, clr;
      logic [15:0] e_addr;
      logic [7:0]  e_data, pp;
      rec_t        r;
      int          k;
      string       tag;
      @(negedge ph1);
      e_busy = 1; e_addr = 0; e_data = 0; e_rd = 1; e_spd = 0;
      e_pcl = 0; e_pch = 0; e_seti = 0; e_done = 0; clr = 0;
      if (reset) begin
         tag = "reset"; q.delete(); m_hold = 1;
      end else if (m_hold) begin
         tag = "rst_hold"; m_hold = 0; queue_seq(KR);
      end else if (q.size() == 0) begin
         tag = "idle"; e_busy = 0;
         if (m_pend && instr_bnd) queue_seq(KN);
         else if (brk_req) queue_seq(KB);
         else if (irq_req && !p[2] && instr_bnd) queue_seq(KI);
      end else begin
         r = q.pop_front();
         tag = $sformatf("seq_k%0d_s%0d", r.kind, r.step);
         if (r.step < 3) begin
            e_addr = {8'h01, sp}; e_spd = 1; e_rd = (r.kind == KR);
            pp = p | 8'h20;
            if (r.kind == KB) pp = pp | 8'h10;
            e_data = (r.step == 0) ? pc[15:8] : (r.step == 1) ? pc[7:0] : pp;
         end else if (r.step == 3) begin
            k = r.kind;
            if ((k == KB || k == KI) && m_pend) k = KN;
            q[0].kind = k;
            e_addr = vec_of(k); e_pcl = 1; e_seti = 1; clr = (k == KN);
         end else begin
            e_addr = vec_of(r.kind) + 16'd1; e_pch = 1; e_done = 1;
         end
      end
      m_pend  = reset ? 1'b0 : ((nmi_req && !m_nprev) || (m_pend && !clr));
      m_nprev = nmi_req;
      o_busy = busy; o_addr = addr_out; o_data = data_out; o_rd = read_en;
      o_spd = sp_dec; o_pcl = pcl_load; o_pch = pch_load; o_seti = set_i; o_done = done;
      chk(tag, {1'b0, busy, addr_out, data_out, read_en, sp_dec, pcl_load, pch_load, set_i, done},
          {1'b0, e_busy, e_addr, e_data, e_rd, e_spd, e_pcl, e_pch, e_seti, e_done});
      @(posedge ph1);
      #1;
      if (e_spd) sp = sp - 8'd1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      reset = 1; nmi_req = 0; irq_req = 0; brk_req = 0; instr_bnd = 0;
      p = 8'h00; pc = 16'h0000; sp = 8'hFD;

      // reset held 3 cycles, then the reset entry sequence
      run(3);
      chk("rst_busy", {31'd0, o_busy}, 32'd1);
      chk("rst_addr", {16'd0, o_addr}, 32'h0000);
      reset = 0;
      tick();
      chk("hold_spd", {31'd0, o_spd}, 32'd0);
      tick(); chk("rst_push0", {15'd0, o_addr, o_rd}, {15'd0, 16'h01FD, 1'b1});
      tick(); chk("rst_push1", {15'd0, o_addr, o_rd}, {15'd0, 16'h01FC, 1'b1});
      tick(); chk("rst_push2", {15'd0, o_addr, o_spd}, {15'd0, 16'h01FB, 1'b1});
      tick(); chk("rst_vlo", {15'd0, o_addr, o_pcl}, {15'd0, 16'hFFFC, 1'b1});
      tick(); chk("rst_vhi", {14'd0, o_addr, o_pch, o_done}, {14'd0, 16'hFFFD, 2'b11});
      tick(); chk("rst_idle", {31'd0, o_busy}, 32'd0);

      // IRQ entry
      sp = 8'hFF; irq_req = 1; p = 8'h00; instr_bnd = 1; pc = 16'h1234;
      tick(); irq_req = 0;
      tick(); chk("irq_pch", {16'd0, o_data, o_rd, 7'd0}, {16'd0, 8'h12, 8'h00});
      tick(); chk("irq_pcl", {16'd0, o_data, 8'd0}, {16'd0, 8'h34, 8'd0});
      tick(); chk("irq_p", {8'd0, o_addr, o_data}, {8'd0, 16'h01FD, 8'h20});
      tick(); chk("irq_vlo", {15'd0, o_addr, o_seti}, {15'd0, 16'hFFFE, 1'b1});
      tick(); chk("irq_vhi", {15'd0, o_addr, o_done}, {15'd0, 16'hFFFF, 1'b1});

      // masked IRQ never enters
      irq_req = 1; p = 8'h04;
      for (int i = 0; i < 20; i++) begin
         tick(); chk("irq_masked", {31'd0, o_busy}, 32'd0);
      end

      // BRK beats a simultaneous IRQ
      p = 8'h00; brk_req = 1;
      tick(); brk_req = 0; irq_req = 0;
      run(2);
      tick(); chk("brk_p", {24'd0, o_data}, 32'h30);
      tick(); chk("brk_vlo", {16'd0, o_addr}, 32'hFFFE);
      run(2);

      // NMI arriving mid-IRQ hijacks the vector only
      irq_req = 1;
      tick(); irq_req = 0;
      tick(); nmi_req = 1;
      tick();
      tick(); chk("hij_p", {24'd0, o_data}, 32'h20);
      tick(); chk("hij_vlo", {16'd0, o_addr}, 32'hFFFA);
      tick(); chk("hij_vhi", {16'd0, o_addr}, 32'hFFFB);
      for (int i = 0; i < 5; i++) begin
         tick(); chk("hij_no_renmi", {31'd0, o_busy}, 32'd0);
      end
      nmi_req = 0;

      // reset during PUSH_P aborts without strobes
      irq_req = 1;
      tick(); irq_req = 0;
      run(2);
      reset = 1;
      tick(); chk("abort_rst", {30'd0, o_busy, o_spd}, 32'b10);
      reset = 0;
      tick(); chk("abort_hold", {30'd0, o_busy, o_spd}, 32'b10);
      run(3);
      tick(); chk("abort_vlo", {16'd0, o_addr}, 32'hFFFC);
      run(1);

      // NMI edge during the reset sequence is serviced after done
      reset = 1; tick(); reset = 0;
      run(2); nmi_req = 1;
      run(2);
      tick(); chk("rstnmi_vlo", {16'd0, o_addr}, 32'hFFFC);
      run(1);
      tick(); chk("rstnmi_accept", {31'd0, o_busy}, 32'd0);
      run(3);
      tick(); chk("rstnmi_vec", {16'd0, o_addr}, 32'hFFFA);
      run(1);
      nmi_req = 0;

      // random traffic against the model
      for (int c = 0; c < 800; c++) begin
         reset     = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 9) == 0) nmi_req = ~nmi_req;
         irq_req   = ($urandom_range(0, 3) == 0);
         brk_req   = ($urandom_range(0, 15) == 0);
         instr_bnd = 1'($urandom_range(0, 1));
         p         = 8'($urandom);
         pc        = 16'($urandom);
         if ($urandom_range(0, 31) == 0) sp = 8'($urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
